golden_checker: RTL and testbench

- Synthesizable end-of-test checker that sits beside the RISCV core in simulation and FPGA bring-up.
- Snoops the core's data-memory bus to detect program completion: a store to a TOHOST address, or a cycle limit.
- Then accepts a streamed register/memory dump and compares each word against a loadable golden table, counting mismatches and raising pass/fail.
- Generalises the fixed-cycle, fixed-32-register compare into parametrised width, depth, start index and termination mode.

---
 rtl/golden_checker_pkg.sv | 23 ++
 rtl/golden_ram.sv | 23 ++
 rtl/golden_checker.sv | 134 +++++++++++++
 tb/tb_golden_checker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/golden_checker_pkg.sv
// Shared types and helpers for the golden_checker end-of-test comparator.
package golden_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned TOHOST_PASS_VAL = 1;

    // Ceiling log2, returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/golden_ram.sv
// Golden reference table: synchronous write, combinational read, no reset.
module golden_ram #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_CHK = 32,
    parameter int unsigned IDX_W   = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [NUM_CHK];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/golden_checker.sv
// End-of-test checker: detects completion on the DM bus, then compares a streamed dump
// against the golden table. GOLDEN_CHECKER_MISMATCH_LOG_EN adds first-mismatch capture ports.
module golden_checker
    import golden_checker_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_CHK        = 32,
    parameter int unsigned FIRST_IDX      = 1,
    parameter int unsigned ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_FFFC),
    parameter int unsigned MAX_CYCLES     = 10000,
    parameter int unsigned REQUIRE_TOHOST = 0,
    localparam int unsigned IDX_W = (clog2(NUM_CHK) > 0) ? clog2(NUM_CHK) : 1,
    localparam int unsigned ERR_W = clog2(NUM_CHK + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dm_en_i,
    input  logic              dm_wen_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_data_i,
    input  logic              gld_we_i,
    input  logic [IDX_W-1:0]  gld_addr_i,
    input  logic [DATA_W-1:0] gld_data_i,
    input  logic              dump_valid_i,
    input  logic [DATA_W-1:0] dump_data_i,
    output logic              dump_ready_o,
    output logic              dump_req_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] tohost_val_o,
    output logic [ERR_W-1:0]  err_cnt_o,
`ifdef GOLDEN_CHECKER_MISMATCH_LOG_EN
    output logic [IDX_W-1:0]  first_bad_idx_o,
    output logic [DATA_W-1:0] first_bad_got_o,
    output logic [DATA_W-1:0] first_bad_exp_o,
`endif
    output logic [31:0]       cycle_cnt_o
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] gld_rd_c;
    logic [ERR_W-1:0]  err_d;
    logic              store_c, limit_c, hs_c, last_c, count_c, pass_d;

    golden_ram #(
        .DATA_W  (DATA_W),
        .NUM_CHK (NUM_CHK),
        .IDX_W   (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (gld_we_i),
        .waddr   (gld_addr_i),
        .wdata   (gld_data_i),
        .raddr   (idx_q),
        .rdata_c (gld_rd_c)
    );

    // Termination and handshake decode; the store outranks the cycle limit.
    always_comb begin
        store_c = (state_q == RUN) && !dm_en_i && !dm_wen_i && (dm_addr_i == TOHOST_ADDR);
        limit_c = (state_q == RUN) && (MAX_CYCLES != 0) &&
                  (cycle_cnt_o == 32'(MAX_CYCLES - 1));
        hs_c    = dump_ready_o && dump_valid_i;
        last_c  = hs_c && (idx_q == IDX_W'(NUM_CHK - 1));
        count_c = hs_c && (dump_data_i != gld_rd_c) && (32'(idx_q) >= 32'(FIRST_IDX));
        err_d   = (count_c && (err_cnt_o != ERR_W'(NUM_CHK))) ? err_cnt_o + ERR_W'(1)
                                                               : err_cnt_o;
        pass_d  = (err_d == '0) && !((REQUIRE_TOHOST != 0) && timeout_o) &&
                  (timeout_o || (tohost_val_o == DATA_W'(TOHOST_PASS_VAL)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (store_c || limit_c) state_d = DUMP;
            DUMP:    if (last_c) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            err_cnt_o    <= '0;
            cycle_cnt_o  <= '0;
            tohost_val_o <= '0;
            timeout_o    <= 1'b0;
            dump_req_o   <= 1'b0;
            dump_ready_o <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_cnt_o    <= err_d;
            dump_req_o   <= (state_d == DUMP);
            dump_ready_o <= (state_d == DUMP);
            if (hs_c) idx_q <= idx_q + IDX_W'(1);
            if ((state_q == RUN) && (cycle_cnt_o != '1)) cycle_cnt_o <= cycle_cnt_o + 32'd1;
            if (store_c) tohost_val_o <= dm_data_i;
            if (limit_c && !store_c) timeout_o <= 1'b1;
            if (last_c) begin
                done_o <= 1'b1;
                pass_o <= pass_d;
            end
        end
    end

`ifdef GOLDEN_CHECKER_MISMATCH_LOG_EN
    // A zero error count marks the first counted mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_bad_idx_o <= '0;
            first_bad_got_o <= '0;
            first_bad_exp_o <= '0;
        end else if (count_c && (err_cnt_o == '0)) begin
            first_bad_idx_o <= idx_q;
            first_bad_got_o <= dump_data_i;
            first_bad_exp_o <= gld_rd_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && count_c)
            $display("golden_checker: mismatch idx=%0d got=%h exp=%h", idx_q, dump_data_i, gld_rd_c);
    end
`endif

endmodule

// File: tb/tb_golden_checker.sv
// Directed bench for golden_checker; instance a has REQUIRE_TOHOST=0, b has REQUIRE_TOHOST=1.
module tb_golden_checker;

    localparam int unsigned NC = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dm_en = 1'b1, dm_wen = 1'b1;
    logic [31:0] dm_addr = '0, dm_data = '0;
    logic        gld_we = 1'b0;
    logic [4:0]  gld_addr = '0;
    logic [31:0] gld_data = '0;
    logic        dump_valid = 1'b0;
    logic [31:0] dump_data = '0;

    logic        a_ready, a_req, a_done, a_pass, a_tmo;
    logic [31:0] a_tohost, a_cyc;
    logic [5:0]  a_err;
    logic        b_ready, b_req, b_done, b_pass, b_tmo;
    logic [31:0] b_tohost, b_cyc;
    logic [5:0]  b_err;
`ifdef GOLDEN_CHECKER_MISMATCH_LOG_EN
    logic [4:0]  a_fb_idx, b_fb_idx;
    logic [31:0] a_fb_got, a_fb_exp, b_fb_got, b_fb_exp;
`endif

    int total = 0;
    int bad   = 0;
    int hs;

    always #5 clk = ~clk;

    golden_checker #(.MAX_CYCLES(100), .REQUIRE_TOHOST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .dm_en_i(dm_en), .dm_wen_i(dm_wen), .dm_addr_i(dm_addr),
        .dm_data_i(dm_data), .gld_we_i(gld_we), .gld_addr_i(gld_addr), .gld_data_i(gld_data),
        .dump_valid_i(dump_valid), .dump_data_i(dump_data), .dump_ready_o(a_ready),
        .dump_req_o(a_req), .done_o(a_done), .pass_o(a_pass), .timeout_o(a_tmo),
        .tohost_val_o(a_tohost), .err_cnt_o(a_err),
`ifdef GOLDEN_CHECKER_MISMATCH_LOG_EN
        .first_bad_idx_o(a_fb_idx), .first_bad_got_o(a_fb_got), .first_bad_exp_o(a_fb_exp),
`endif
        .cycle_cnt_o(a_cyc)
    );

    golden_checker #(.MAX_CYCLES(100), .REQUIRE_TOHOST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .dm_en_i(dm_en), .dm_wen_i(dm_wen), .dm_addr_i(dm_addr),
        .dm_data_i(dm_data), .gld_we_i(gld_we), .gld_addr_i(gld_addr), .gld_data_i(gld_data),
        .dump_valid_i(dump_valid), .dump_data_i(dump_data), .dump_ready_o(b_ready),
        .dump_req_o(b_req), .done_o(b_done), .pass_o(b_pass), .timeout_o(b_tmo),
        .tohost_val_o(b_tohost), .err_cnt_o(b_err),
`ifdef GOLDEN_CHECKER_MISMATCH_LOG_EN
        .first_bad_idx_o(b_fb_idx), .first_bad_got_o(b_fb_got), .first_bad_exp_o(b_fb_exp),
`endif
        .cycle_cnt_o(b_cyc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // All registered outputs of instance a, packed for a single zero check.
    function automatic logic [63:0] a_outs();
        return {a_ready, a_req, a_done, a_pass, a_tmo, a_err, 32'(a_tohost | a_cyc)};
    endfunction

    task automatic do_reset();
        dump_valid = 1'b0;
        dm_en = 1'b1; dm_wen = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input logic [31:0] v);
        for (int n = 0; n < 300 && a_cyc != v; n++) @(negedge clk);
        chk("reach_cycle", 64'(a_cyc), 64'(v));
    endtask

    task automatic store(input logic [31:0] d);
        dm_en = 1'b0; dm_wen = 1'b0; dm_addr = 32'h0000_FFFC; dm_data = d;
        @(negedge clk);
        dm_en = 1'b1; dm_wen = 1'b1; dm_addr = '0; dm_data = '0;
    endtask

    // Streams words i ^ badm[i]; stops after stop_at handshakes.
    task automatic run_dump(input logic [31:0] badm, input bit rnd, input int stop_at,
                            output int n_hs);
        int n;
        n_hs = 0;
        for (n = 0; n < 50 && !a_ready; n++) @(negedge clk);
        chk("dump_req", 64'(a_req), 64'd1);
        for (n = 0; n < 2000 && n_hs < stop_at; n++) begin
            dump_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dump_data  = 32'(n_hs) ^ 32'(badm[n_hs]);
            if (dump_valid && n_hs == NC - 1) chk("done_early", 64'(a_done), 64'd0);
            if (dump_valid && a_ready) n_hs++;
            @(negedge clk);
        end
        dump_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outs", a_outs(), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            gld_we = 1'b1; gld_addr = 5'(i); gld_data = 32'(i);
        end
        @(negedge clk);
        gld_we = 1'b0;

        // Clean run ending on TOHOST store of 1; stray valid during RUN ignored.
        dump_valid = 1'b1; dump_data = 32'hDEAD_BEEF;
        wait_cnt(50);
        chk("ready_in_run", 64'(a_ready), 64'd0);
        dump_valid = 1'b0;
        store(32'h1);
        run_dump(32'h0, 1'b0, NC, hs);
        chk("t1_hs", 64'(hs), 64'd32);
        chk("t1_done", 64'(a_done), 64'd1);
        chk("t1_tmo", 64'(a_tmo), 64'd0);
        chk("t1_err", 64'(a_err), 64'd0);
        chk("t1_pass", 64'(a_pass), 64'd1);
        chk("t1_pass_b", 64'(b_pass), 64'd1);
        chk("t1_tohost", 64'(a_tohost), 64'd1);
        chk("t1_rdy_drop", 64'({a_ready, a_req}), 64'd0);

        // Words 5 and 17 corrupted.
        do_reset();
        wait_cnt(50);
        store(32'h1);
        run_dump(32'h0002_0020, 1'b0, NC, hs);
        chk("t2_err", 64'(a_err), 64'd2);
        chk("t2_pass", 64'(a_pass), 64'd0);
`ifdef GOLDEN_CHECKER_MISMATCH_LOG_EN
        chk("t2_fb_idx", 64'(a_fb_idx), 64'd5);
        chk("t2_fb_got", 64'(a_fb_got), 64'd4);
        chk("t2_fb_exp", 64'(a_fb_exp), 64'd5);
`endif

        // No store: cycle limit ends the run.
        do_reset();
        for (int n = 0; n < 300 && !a_ready; n++) @(negedge clk);
        chk("t3_cyc", 64'(a_cyc), 64'd100);
        chk("t3_tmo", 64'(a_tmo), 64'd1);
        run_dump(32'h0, 1'b0, NC, hs);
        chk("t3_done", 64'({a_done, b_done}), 64'b11);
        chk("t3_pass_a", 64'(a_pass), 64'd1);
        chk("t3_pass_b", 64'(b_pass), 64'd0);

        // Word 0 wrong (skipped index) with random valid.
        do_reset();
        wait_cnt(50);
        store(32'h1);
        run_dump(32'h0000_0001, 1'b1, NC, hs);
        chk("t4_hs", 64'(hs), 64'd32);
        chk("t4_done", 64'(a_done), 64'd1);
        chk("t4_err", 64'(a_err), 64'd0);
        chk("t4_pass", 64'(a_pass), 64'd1);

        // Store coincides with the cycle limit.
        do_reset();
        wait_cnt(99);
        store(32'h1);
        chk("t5_tmo", 64'(a_tmo), 64'd0);
        chk("t5_tohost", 64'(a_tohost), 64'd1);
        chk("t5_cyc", 64'(a_cyc), 64'd100);
        run_dump(32'h0, 1'b0, NC, hs);
        chk("t5_pass", 64'({a_pass, b_pass}), 64'b11);

        // Store value 2 is a failing exit even with a clean dump.
        do_reset();
        wait_cnt(50);
        store(32'h2);
        run_dump(32'h0, 1'b0, NC, hs);
        chk("t6_tohost", 64'(a_tohost), 64'd2);
        chk("t6_err", 64'(a_err), 64'd0);
        chk("t6_done", 64'(a_done), 64'd1);
        chk("t6_pass", 64'(a_pass), 64'd0);

        // Asynchronous reset mid-dump, then rerun with retained golden contents.
        do_reset();
        wait_cnt(50);
        store(32'h1);
        run_dump(32'h0, 1'b0, 10, hs);
        #2 rst_n = 1'b0;
        #1 chk("t7_async_rst", a_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cnt(50);
        store(32'h1);
        run_dump(32'h0, 1'b0, NC, hs);
        chk("t7_done", 64'(a_done), 64'd1);
        chk("t7_err", 64'(a_err), 64'd0);
        chk("t7_pass", 64'(a_pass), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
